// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared types and encodings for the cmd_seq command sequencer.
// Holds the FSM state enum, the transaction layout at the default widths
// and the cmd encodings seen by the downstream loadable counter.
package cmd_seq_pkg;

  // Default widths of the sequencer and of the counter it drives.
  localparam int CMD_SEQ_N     = 8;
  localparam int CMD_SEQ_CW    = 4;
  localparam int CMD_SEQ_DEPTH = 4;

  // Encodings of the counter's cmd input.
  localparam logic CMD_LOAD = 1'b0;
  localparam logic CMD_INC  = 1'b1;

  // Sequencer FSM state; exported on the debug port of the top level.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_INC  = 2'd2
  } seq_state_e;

  // One queued transaction at the default widths: load value, then incs
  // increment cycles. The top level packs {value, incs} in this order.
  typedef struct packed {
    logic [CMD_SEQ_N-1:0]  value;
    logic [CMD_SEQ_CW-1:0] incs;
  } txn_t;

endpackage

// File: rtl/cmd_seq_fifo.sv
// cmd_seq_fifo: synchronous FIFO with full/empty flags and occupancy count.
// No bypass: a word written at one edge is readable from the next cycle on.
// A push while full is dropped even if a pop happens in the same cycle.
module cmd_seq_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^k.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cmd_seq.sv
// cmd_seq: command sequencer in front of the loadable counter stage.
// Each queued {value, incs} transaction becomes one load cycle followed by
// incs increment cycles on cmd/data. While idle, the shadow copy of the
// counter is re-loaded every cycle so the counter holds its value.
// Optional feature macro: CMD_SEQ_DONE_EN adds a one-cycle 'done' output
// marking the last emitted cycle of each transaction.
module cmd_seq
  import cmd_seq_pkg::*;
#(
  parameter int N     = CMD_SEQ_N,
  parameter int CW    = CMD_SEQ_CW,
  parameter int DEPTH = CMD_SEQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  // Handshake: a transaction transfers at a rising edge where in_valid and
  // in_ready are both 1. in_ready comes from registered FIFO state only and
  // never looks at in_valid; in_value/in_incs must be stable while in_valid=1.
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_value,
  input  logic [CW-1:0] in_incs,
  output logic          cmd,
  output logic [N-1:0]  data,
  output logic          busy,
  output seq_state_e    dbg_state
`ifdef CMD_SEQ_DONE_EN
  ,
  output logic          done
`endif
);

  localparam int W = N + CW;

  seq_state_e            state;
  logic [CW-1:0]         rem;
  logic [N-1:0]          shadow;

  logic [W-1:0]          fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [N-1:0]          head_value;
  logic [CW-1:0]         head_incs;
  logic                  take_next;
  logic                  pop;

  // Transaction buffer; entries are packed {value, incs}.
  cmd_seq_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_value, in_incs}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_value = fifo_rdata[W-1:CW];
  assign head_incs  = fifo_rdata[CW-1:0];

  // A new transaction may start when idle or when the current one has
  // issued its last cycle (no increments left).
  assign take_next = (state == ST_IDLE) || (rem == '0);
  assign pop       = take_next && !fifo_empty;

  assign in_ready  = !fifo_full;
  assign busy      = (state != ST_IDLE) || (fifo_count != '0);
  assign dbg_state = state;

  // Sequencer FSM: pick the next transaction, step increments, or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rem    <= '0;
      shadow <= '0;
      cmd    <= CMD_LOAD;
      data   <= '0;
    end else if (take_next) begin
      if (!fifo_empty) begin
        state  <= ST_LOAD;
        cmd    <= CMD_LOAD;
        data   <= head_value;
        shadow <= head_value;
        rem    <= head_incs;
      end else begin
        // Nothing queued: keep re-loading the counter with its own value.
        state  <= ST_IDLE;
        cmd    <= CMD_LOAD;
        data   <= shadow;
        rem    <= '0;
      end
    end else begin
      // data carries the pre-increment value so it is never left undefined.
      state  <= ST_INC;
      cmd    <= CMD_INC;
      data   <= shadow;
      shadow <= shadow + N'(1);
      rem    <= rem - CW'(1);
    end
  end

`ifdef CMD_SEQ_DONE_EN
  // done rides along with the last cycle: a zero-increment load or final INC.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else if (take_next) begin
      done <= !fifo_empty && (head_incs == '0);
    end else begin
      done <= (rem == CW'(1));
    end
  end
`endif

endmodule

// File: tb/tb_cmd_seq.sv
// tb_cmd_seq: directed bench for cmd_seq with a model of the downstream
// loadable counter (cmd=0 loads data, cmd=1 increments, wraps mod 256).
module tb_cmd_seq;
  import cmd_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_value = 8'h00;
  logic [3:0] in_incs = 4'h0;
  logic       cmd;
  logic [7:0] data;
  logic       busy;
  seq_state_e dbg_state;
`ifdef CMD_SEQ_DONE_EN
  logic       done;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] cnt;

  // Emitted-cycle log for ordering / gap checks.
  bit         log_en = 1'b0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         cyc_q[$];

  cmd_seq #(.N(8), .CW(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_incs   (in_incs),
    .cmd       (cmd),
    .data      (data),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef CMD_SEQ_DONE_EN
    ,
    .done      (done)
`endif
  );

  // Clock and cycle count.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream counter model.
  always @(posedge clk) begin
    if (rst)                 cnt <= 8'h00;
    else if (cmd == CMD_LOAD) cnt <= data;
    else                     cnt <= cnt + 8'h01;
  end

  // Record every non-idle output cycle.
  always @(negedge clk) begin
    if (log_en && dbg_state != ST_IDLE) begin
      got_q.push_back({cmd, data});
      cyc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    while (busy && t < budget) begin
      tick();
      t++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit accepted;

    // ---- Reset: two cycles, then idle for 10 cycles ----
    tick();
    tick();
    rst = 1'b0;
    check("rst_cmd", cmd, 0);
    check("rst_data", data, 8'h00);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
`ifdef CMD_SEQ_DONE_EN
    check("rst_done", done, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_idle_cnt", cnt, 8'h00);
    end

    // ---- Single transaction {0x10, 3} ----
    in_valid = 1'b1; in_value = 8'h10; in_incs = 4'd3;
    tick();
    in_valid = 1'b0;
    check("t1_busy_queued", busy, 1);
    check("t1_still_idle", dbg_state, ST_IDLE);
    tick();
    check("t1_load_cmd", cmd, 0);
    check("t1_load_data", data, 8'h10);
    check("t1_load_cnt", cnt, 8'h00);
    tick();
    check("t1_inc1_cmd", cmd, 1);
    check("t1_inc1_data", data, 8'h10);
    check("t1_inc1_cnt", cnt, 8'h10);
`ifdef CMD_SEQ_DONE_EN
    check("t1_inc1_done", done, 0);
`endif
    tick();
    check("t1_inc2_cmd", cmd, 1);
    check("t1_inc2_data", data, 8'h11);
    tick();
    check("t1_inc3_cmd", cmd, 1);
    check("t1_inc3_data", data, 8'h12);
`ifdef CMD_SEQ_DONE_EN
    check("t1_inc3_done", done, 1);
`endif
    tick();
    check("t1_hold_cmd", cmd, 0);
    check("t1_hold_data", data, 8'h13);
    check("t1_hold_cnt", cnt, 8'h13);
    check("t1_hold_busy", busy, 0);
`ifdef CMD_SEQ_DONE_EN
    check("t1_hold_done", done, 0);
`endif
    tick();
    check("t1_hold2_cnt", cnt, 8'h13);

    // ---- Wrap {0xFE, 3} ----
    in_valid = 1'b1; in_value = 8'hFE; in_incs = 4'd3;
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap_load_data", data, 8'hFE);
    tick();
    check("wrap_cnt0", cnt, 8'hFE);
    tick();
    check("wrap_cnt1", cnt, 8'hFF);
    check("wrap_inc_data", data, 8'hFF);
    tick();
    check("wrap_cnt2", cnt, 8'h00);
    tick();
    check("wrap_cnt3", cnt, 8'h01);
    check("wrap_idle_data", data, 8'h01);
    check("wrap_idle_cmd", cmd, 0);

    // ---- Back-pressure: six {k, 2} pushes into a depth-4 FIFO ----
    got_q.delete(); cyc_q.delete(); exp_q.delete();
    log_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_value = 8'(k); in_incs = 4'd2;
      accepted = 1'b0;
      for (int t = 0; t < 40 && !accepted; t++) begin
        accepted = in_ready;
        tick();
      end
      check("bp_accept", {31'd0, accepted}, 32'd1);
    end
    in_valid = 1'b0;
    check("bp_full_ready", in_ready, 0);
    wait_idle("bp_drain", 60);
    log_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back({1'b0, 8'(k)});
      exp_q.push_back({1'b1, 8'(k)});
      exp_q.push_back({1'b1, 8'(k + 1)});
    end
    check("bp_count", got_q.size(), 18);
    for (int i = 0; i < 18 && i < got_q.size(); i++)
      check("bp_seq", got_q[i], exp_q[i]);
    if (cyc_q.size() == 18)
      check("bp_no_gap", cyc_q[17] - cyc_q[0], 17);
    check("bp_final_cnt", cnt, 8'h07);
    check("bp_final_data", data, 8'h07);
    check("bp_ready_back", in_ready, 1);

    // ---- Zero increments back to back ----
    in_valid = 1'b1; in_value = 8'h20; in_incs = 4'd0;
    tick();
    in_value = 8'h30;
    tick();
    in_valid = 1'b0;
    check("z_load1_state", dbg_state, ST_LOAD);
    check("z_load1_data", data, 8'h20);
    check("z_load1_cmd", cmd, 0);
`ifdef CMD_SEQ_DONE_EN
    check("z_load1_done", done, 1);
`endif
    tick();
    check("z_load2_state", dbg_state, ST_LOAD);
    check("z_load2_data", data, 8'h30);
`ifdef CMD_SEQ_DONE_EN
    check("z_load2_done", done, 1);
`endif
    tick();
    check("z_hold_state", dbg_state, ST_IDLE);
    check("z_hold_data", data, 8'h30);
    check("z_hold_cnt", cnt, 8'h30);
`ifdef CMD_SEQ_DONE_EN
    check("z_hold_done", done, 0);
`endif

    // ---- Reset in the middle of {0x40, 15} with two queued ----
    in_valid = 1'b1; in_value = 8'h40; in_incs = 4'd15;
    tick();
    in_value = 8'h55; in_incs = 4'd1;
    tick();
    in_value = 8'h66;
    tick();
    in_valid = 1'b0;
    check("mr_inc1_data", data, 8'h40);
    tick(); tick(); tick(); tick();
    check("mr_inc5_cmd", cmd, 1);
    check("mr_inc5_data", data, 8'h44);
    check("mr_inc5_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_cmd", cmd, 0);
    check("mr_data", data, 8'h00);
    check("mr_busy", busy, 0);
    check("mr_ready", in_ready, 1);
    check("mr_state", dbg_state, ST_IDLE);
    got_q.delete(); cyc_q.delete();
    log_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    log_en = 1'b0;
    check("mr_no_emit", got_q.size(), 0);
    check("mr_cnt", cnt, 8'h00);
    check("mr_idle_data", data, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_seq.md
# cmd_seq

Upstream command sequencer for the loadable counter stage. Accepts `{value, increments}` transactions on a valid/ready interface and buffers them in a small FIFO. For each transaction it drives the counter's `cmd`/`data` pair as one load cycle followed by the requested number of increment cycles. Between transactions it keeps a shadow copy of the counter value and re-loads it, so the counter holds steady.

## Interface
- `N`, 8, data width; equals the counter's `N`
- `CW`, 4, width of the increment-count field
- `DEPTH`, 4, transaction FIFO depth; power of two, at least 2
- `clk` input 1 — the single clock; all state updates on rising edge
- `rst` input 1 — reset; one clock, reset is synchronous and active-high
- `in_valid` input 1 — transaction offered
- `in_ready` output 1 — FIFO can accept; equals `!full`
- `in_value` input N — value to load
- `in_incs` input CW — number of increment cycles after the load (0 to 2^CW−1)
- `cmd` output 1 — to counter: 0 = load `data`, 1 = increment
- `data` output N — to counter load data
- `busy` output 1 — `(state != IDLE) || !empty`

## Operation
- Transfer occurs when `in_valid && in_ready` at a rising edge; `{in_value, in_incs}` is pushed.
- FIFO: no bypass. An entry pushed at edge k can be popped at edge k+1 at the earliest. When full, `in_ready`=0 and no push occurs, even if a pop happens in the same cycle.
- Registered state: `state` ∈ {IDLE, LOAD, INC}, `rem` (CW bits), `shadow` (N bits), `cmd` and `data` registers.
- At each edge, when `state` is IDLE, or when `state` is LOAD/INC with `rem`==0:
  - FIFO non-empty: pop; `state`←LOAD, `cmd`←0, `data`←value, `shadow`←value, `rem`←incs.
  - FIFO empty: `state`←IDLE, `cmd`←0, `data`←`shadow` (hold the counter).
- At each edge, when `state` is LOAD/INC with `rem`>0: `state`←INC, `cmd`←1, `rem`←`rem`−1, `shadow`←`shadow`+1.
- Arithmetic: `shadow` wraps modulo 2^N (0xFF+1 = 0x00 for N=8). `data` is don't-care-free: in INC it drives `shadow`'s pre-increment value.
- Invariant: after the edge following any emitted cycle, counter `dout` equals `shadow`.
- Transactions execute strictly in FIFO order. With `incs`=0, back-to-back transactions give consecutive load cycles with no IDLE gap.

## Timing
- Reset (rst=1 at an edge): `state`=IDLE, `rem`=0, `shadow`=0, `cmd`=0, `data`=0, FIFO empty. Hence `in_ready`=1 and `busy`=0 in the next cycle. This matches the counter's reset value of 0.
- Reset mid-transaction: the FIFO is flushed, the current transaction is abandoned, and the outputs return to load-0.
- Latency: a push at edge k presents the load on `cmd`/`data` after edge k+1 when idle; the counter shows the value after edge k+2.
- One transaction occupies exactly 1+incs output cycles.
- `in_ready` is registered-derived (from the FIFO count) and does not depend on `in_valid`.

## Configuration
- `CMD_SEQ_DONE_EN` defined: adds output `done` (1 bit, reset 0). `done` is high for exactly one cycle, coincident with the last emitted cycle of each transaction (the load cycle if `incs`=0, otherwise the final INC cycle).
- Undefined: no `done` port and no associated logic; all other behaviour is identical.

## Structure
- Package `cmd_seq_pkg`: `state` enum type, transaction struct typedef `{value[N-1:0], incs[CW-1:0]}`, and encoding constants `CMD_LOAD`=0 and `CMD_INC`=1.
- Sub-module `cmd_seq_fifo`: synchronous FIFO, parameterised by width and `DEPTH`, with `full`/`empty` flags and an occupancy count. The top level holds the FSM, the `shadow` register and the output registers.

## Test plan
- Reset: hold rst=1 for 2 cycles, then release → `cmd`=0, `data`=0, `in_ready`=1, `busy`=0; counter `dout` stays 0 for 10 idle cycles.
- Single transaction {0x10, 3} → `cmd`/`data` sequence 0/0x10, 1, 1, 1, then 0/0x13 held; counter `dout` settles at 0x13; `done` pulses on the 4th cycle when enabled.
- Wrap: {0xFE, 3} → `shadow` and `dout` go 0xFE, 0xFF, 0x00, 0x01; idle `data`=0x01.
- Back-pressure: with DEPTH=4, push 6 transactions of {k, 2} while busy → `in_ready` drops after the FIFO fills; all 6 execute in order with no gaps; final `dout` = 5+2 = 0x07.
- Zero increments back-to-back: {0x20, 0} then {0x30, 0} → consecutive cycles with `cmd`=0, `data`=0x20 then 0x30, then hold at 0x30.
- Reset mid-INC: start {0x40, 15} with 2 entries queued, assert rst on the 5th INC cycle → next cycle `cmd`=0, `data`=0, FIFO empty, `busy`=0; queued transactions are never emitted.
